pulse_event_counter: RTL and testbench
======================================

// Module: pulse_event_counter
// PURPOSE
//  Downstream consumer of the serial detector's 1-bit `out` stream (wired to `in` here).
//  Counts rising edges of that stream, flags a programmable threshold and sticky overflow,
//  and offers a snapshot-and-clear readout over a req/valid/ack handshake.
//  Sits between the detector and any host/display logic that polls event totals.
// PARAMETERS
//  WIDTH        8   counter / readout width in bits
//  THRESH       5   thresh_hit asserts when count >= THRESH (0 < THRESH <= 2^WIDTH-1)
//  SATURATE     1   1: count sticks at 2^WIDTH-1; 0: count wraps to 0
//  CLR_ON_READ  1   1: snapshot clears count and overflow; 0: snapshot leaves them intact
// PORTS
//  clk        in   1      single clock, all state on posedge
//  reset      in   1      synchronous, active-high; sampled on posedge clk
//  in         in   1      detector output stream, synchronous to clk
//  rd_req     in   1      request snapshot of count (honoured in IDLE only)
//  rd_ack     in   1      consumer accepted rd_data (honoured in HOLD only)
//  count      out  WIDTH  live event count (registered)
//  rd_data    out  WIDTH  snapshot value, stable while rd_valid=1
//  rd_valid   out  1      snapshot available
//  thresh_hit out  1      count >= THRESH (decoded from registered count)
//  overflow   out  1      sticky: an event occurred with count == 2^WIDTH-1
// BEHAVIOUR
//  Reset: in_d=0, count=0, rd_data=0, rd_valid=0, overflow=0, FSM=IDLE; thresh_hit=0 follows.
//   Reset mid-handshake drops the pending snapshot; no ack is required afterwards.
//  Edge detect: event = in & ~in_d; in_d <= in each cycle.
//   in=1 on the first cycle after reset counts as an event (in_d resets to 0).
//   A level held high counts once; re-arming needs at least one cycle of in=0.
//  Count latency: event sampled at edge n -> count updated and visible after edge n (1 cycle).
//  count_next = count+1 on event, else count.
//   At count == 2^WIDTH-1 with an event: SATURATE=1 -> hold; SATURATE=0 -> 0.
//   In both cases overflow <= 1 (sticky until reset or a clearing read).
//  thresh_hit = (count >= THRESH); purely combinational from the count register.
//   Drops when count clears or wraps.
//  FSM, 2 states:
//   IDLE: rd_valid=0. On rd_req=1: rd_data <= count_next (a same-cycle event is included,
//     never lost); if CLR_ON_READ then count <= 0 and overflow <= 0; go to HOLD.
//     rd_ack is ignored in IDLE, including when it coincides with rd_req.
//   HOLD: rd_valid=1; rd_data frozen; counting continues; rd_req ignored.
//     On rd_ack=1: go to IDLE; rd_valid is 0 from the next cycle.
//     A new rd_req is honoured no earlier than the cycle after the return to IDLE.
//  Overflow precedence (CLR_ON_READ=1): a read in the same cycle as an overflowing event
//   clears overflow.
//   With SATURATE=0, the snapshot of that cycle is 0.
//  No combinational path from any input to any output.
// TESTING
//  T1 reset 2 cycles; in = 0,1,0,1 (one value per 10ns clk) -> count=2, thresh_hit=0.
//  T2 in held 1 for 4 cycles then 0 -> count=1; a second high pulse -> count=2.
//  T3 5 single-cycle pulses (THRESH=5) -> thresh_hit=0 after the 4th; =1 the cycle after the 5th.
//  T4 WIDTH=8: 260 pulses.
//     SATURATE=1 -> count=255, overflow=1.
//     SATURATE=0 -> count=4, overflow=1.
//  T5 count=3; rd_req=1 in the same cycle as an edge.
//     -> next cycle rd_valid=1, rd_data=4, count=0.
//     rd_req during HOLD -> no change; rd_ack -> rd_valid=0 the following cycle.
//  T6 rd_valid=1 and count=7; assert reset for 1 cycle -> all outputs 0, FSM IDLE;
//     a stray rd_ack afterwards -> no effect.

Source files
------------

// File: rtl/pulse_event_counter.sv
// Rising-edge event counter with threshold flag, sticky overflow and a
// req/valid/ack snapshot readout. All outputs come straight from registers.
module pulse_event_counter #(
  parameter int WIDTH       = 8,
  parameter int THRESH      = 5,
  parameter int SATURATE    = 1,
  parameter int CLR_ON_READ = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             rd_req,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             thresh_hit,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] THRESH_V = WIDTH'(THRESH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic             in_d_r;
  logic [WIDTH-1:0] count_r, count_inc_s, count_next_s;
  logic [WIDTH-1:0] rd_data_r, rd_data_next_s;
  logic             rd_valid_r;
  logic             overflow_r, overflow_next_s;
  logic             thresh_r;
  logic             event_s;
  logic             ovf_evt_s;

  // Edge detect and the saturating/wrapping increment
  always_comb begin
    event_s     = in & ~in_d_r;
    ovf_evt_s   = 1'b0;
    count_inc_s = count_r;
    if (event_s) begin
      if (count_r == CNT_MAX) begin
        ovf_evt_s   = 1'b1;
        count_inc_s = (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
      end else begin
        count_inc_s = count_r + CNT_ONE;
      end
    end else begin
      count_inc_s = count_r;
    end
  end

  // Readout FSM: snapshot includes a same-cycle event; clearing read beats overflow
  always_comb begin
    state_next_s    = state_r;
    count_next_s    = count_inc_s;
    overflow_next_s = overflow_r | ovf_evt_s;
    rd_data_next_s  = rd_data_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_req) begin
          rd_data_next_s = count_inc_s;
          state_next_s   = ST_HOLD;
          if (CLR_ON_READ != 0) begin
            count_next_s    = CNT_ZERO;
            overflow_next_s = 1'b0;
          end else begin
            count_next_s    = count_inc_s;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (rd_ack) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; threshold is decoded from the next count so it tracks count exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      in_d_r     <= 1'b0;
      count_r    <= CNT_ZERO;
      rd_data_r  <= CNT_ZERO;
      rd_valid_r <= 1'b0;
      overflow_r <= 1'b0;
      thresh_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_d_r     <= in;
      count_r    <= count_next_s;
      rd_data_r  <= rd_data_next_s;
      rd_valid_r <= (state_next_s == ST_HOLD);
      overflow_r <= overflow_next_s;
      thresh_r   <= (count_next_s >= THRESH_V);
    end
  end

  assign count      = count_r;
  assign rd_data    = rd_data_r;
  assign rd_valid   = rd_valid_r;
  assign thresh_hit = thresh_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_pulse_event_counter.sv
// Bench for pulse_event_counter: two configurations driven in parallel, directed
// scenarios followed by random traffic, all checked against a cycle-level model.
module tb_pulse_event_counter;

  localparam int W   = 8;
  localparam int MAX = 255;
  localparam int TH  = 5;

  logic clk;
  logic reset, in, rd_req, rd_ack;
  logic [W-1:0] count0, rd_data0, count1, rd_data1;
  logic rd_valid0, thresh0, ovf0, rd_valid1, thresh1, ovf1;

  int checks = 0;
  int errors = 0;

  // model state, index 0: saturate + clear-on-read, index 1: wrap + non-clearing
  int m_prev;
  int m_cnt [2];
  int m_ovf [2];
  int m_val [2];
  int m_snap[2];
  int m_sat [2] = '{1, 0};
  int m_clr [2] = '{1, 0};

  pulse_event_counter #(.WIDTH(W), .THRESH(TH), .SATURATE(1), .CLR_ON_READ(1)) dut0 (
    .clk(clk), .reset(reset), .in(in), .rd_req(rd_req), .rd_ack(rd_ack),
    .count(count0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .thresh_hit(thresh0), .overflow(ovf0));

  pulse_event_counter #(.WIDTH(W), .THRESH(TH), .SATURATE(0), .CLR_ON_READ(0)) dut1 (
    .clk(clk), .reset(reset), .in(in), .rd_req(rd_req), .rd_ack(rd_ack),
    .count(count1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .thresh_hit(thresh1), .overflow(ovf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the reference behaviour, applied to both configurations
  task automatic model_step();
    int ev;
    int nc;
    ev = (in == 1'b1 && m_prev == 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_ovf[k] = 0; m_val[k] = 0; m_snap[k] = 0;
      end else begin
        nc = m_cnt[k] + ev;
        if (nc > MAX) begin
          m_ovf[k] = 1;
          nc = (m_sat[k] != 0) ? MAX : nc % (MAX + 1);
        end
        if (m_val[k] == 0 && rd_req == 1'b1) begin
          m_snap[k] = nc;
          m_val[k]  = 1;
          if (m_clr[k] != 0) begin
            nc = 0;
            m_ovf[k] = 0;
          end
        end else if (m_val[k] != 0 && rd_ack == 1'b1) begin
          m_val[k] = 0;
        end
        m_cnt[k] = nc;
      end
    end
    m_prev = reset ? 0 : int'(in);
  endtask

  task automatic check_all();
    check("count0",   int'(count0),    m_cnt[0]);
    check("thresh0",  int'(thresh0),   (m_cnt[0] >= TH) ? 1 : 0);
    check("ovf0",     int'(ovf0),      m_ovf[0]);
    check("valid0",   int'(rd_valid0), m_val[0]);
    check("rd_data0", int'(rd_data0),  m_snap[0]);
    check("count1",   int'(count1),    m_cnt[1]);
    check("thresh1",  int'(thresh1),   (m_cnt[1] >= TH) ? 1 : 0);
    check("ovf1",     int'(ovf1),      m_ovf[1]);
    check("valid1",   int'(rd_valid1), m_val[1]);
    check("rd_data1", int'(rd_data1),  m_snap[1]);
  endtask

  task automatic step(input logic i, input logic rq, input logic ak, input logic rs);
    in = i; rd_req = rq; rd_ack = ak; reset = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    m_prev = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ovf[k] = 0; m_val[k] = 0; m_snap[k] = 0;
    end
    in = 1'b0; rd_req = 1'b0; rd_ack = 1'b0; reset = 1'b1;

    // T1: reset state, then 0,1,0,1
    do_reset();
    check("t1_reset_count", int'(count0), 0);
    check("t1_reset_valid", int'(rd_valid0), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_count", int'(count0), 2);
    check("t1_thresh", int'(thresh0), 0);

    // T2: held level counts once
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_level_once", int'(count0), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_second", int'(count0), 2);

    // T3: threshold boundary
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("t3_thresh_after4", int'(thresh0), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_thresh_after5", int'(thresh0), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // T4: 260 pulses, saturate vs wrap
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("t4_sat_count", int'(count0), 255);
    check("t4_sat_ovf", int'(ovf0), 1);
    check("t4_wrap_count", int'(count1), 4);
    check("t4_wrap_ovf", int'(ovf1), 1);
    check("t4_wrap_thresh", int'(thresh1), 0);

    // T5: read coinciding with an edge, req in HOLD, ack
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_valid", int'(rd_valid0), 1);
    check("t5_data", int'(rd_data0), 4);
    check("t5_cleared", int'(count0), 0);
    check("t5_noclr_count", int'(count1), 4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_hold_data", int'(rd_data0), 4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_ack_drop", int'(rd_valid0), 0);

    // T6: reset mid-handshake, then stray ack
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("t6_pre_count", int'(count0), 7);
    check("t6_pre_valid", int'(rd_valid0), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_count", int'(count0), 0);
    check("t6_rst_valid", int'(rd_valid0), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_stray_ack", int'(rd_valid0), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(1, 0)),
           1'($urandom_range(7, 0) == 0),
           1'($urandom_range(3, 0) == 0),
           1'($urandom_range(299, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
